enemy_spawn_scheduler: RTL
==========================

# enemy_spawn_scheduler

Game-level scheduler that owns the pool of enemy slots. It decides when and where each enemy is spawned, tracks which slots are alive, retires slots on kill requests from hit detection, and sequences waves. It sits above the per-enemy motion/animation controllers: its `Enemy_Alive` and spawn outputs initialise and enable each enemy instance.

## Interface

**Parameters**
- `NUM_ENEMY`, default 4: number of enemy slots, 2..8.
- `SPAWN_INTERVAL`, default 120: frames between successive spawns within a wave, ≥1.
- `WAVE_SIZE`, default 8: enemies spawned per wave, 1..255.
- `WAVE_GAP`, default 240: frames of rest after a wave is cleared, ≥1.

**Ports**
- `frame_clk`, in, 1: frame clock, one edge per video frame.
- `Reset`, in, 1: synchronous, active-high.
- `Start`, in, 1: level. Begins a game from IDLE or GAME_OVER.
- `Player_Dead`, in, 1: level. Ends the game.
- `Kill_Req`, in, NUM_ENEMY: bit i set means enemy i was hit this frame.
- `Enemy_Alive`, out, NUM_ENEMY: slot-alive mask.
- `Spawn_Valid`, out, 1: one-frame pulse when a slot is spawned.
- `Spawn_Slot`, out, 3: index of the slot spawned; valid with `Spawn_Valid`.
- `Spawn_X`, out, 9: spawn X position; valid with `Spawn_Valid`.
- `Spawn_Y`, out, 9: spawn Y position; valid with `Spawn_Valid`.
- `Wave_Num`, out, 4: current wave, 1-based, saturates at 15.
- `Kill_Count`, out, 8: total kills this game, saturates at 255.
- `Game_Over`, out, 1: high while in GAME_OVER.

## Operation

**States:** IDLE, SPAWNING, WAIT_CLEAR, WAVE_REST, GAME_OVER.

**Transitions**
- IDLE → SPAWNING on `Start`. This clears the alive mask, `Kill_Count` and the spawn counter, sets `Wave_Num`=1, and loads timer=0.
- In SPAWNING, when timer==0 and a free slot exists:
  - spawn into the lowest-index free slot;
  - increment the spawn counter;
  - reload timer=SPAWN_INTERVAL-1.
- In SPAWNING, when timer≠0: decrement the timer.
- In SPAWNING, when timer==0 and no free slot exists: hold timer at 0 and retry every frame.
- SPAWNING → WAIT_CLEAR on the edge where the spawn counter reaches WAVE_SIZE.
- WAIT_CLEAR → WAVE_REST when the alive mask is all zero. Load timer=WAVE_GAP-1.
- WAVE_REST: decrement the timer. At 0, go to SPAWNING with timer=0, spawn counter=0 and `Wave_Num`+1 (saturating).
- SPAWNING, WAIT_CLEAR or WAVE_REST → GAME_OVER when `Player_Dead`=1. This has priority over every other transition in the same frame.
  - The alive mask, `Kill_Count` and `Wave_Num` freeze.
  - No spawns occur and `Kill_Req` is ignored.
- GAME_OVER → SPAWNING on `Start`, with the same initialisation as leaving IDLE.

**Spawn positions**
- Points are used in rotating order, advanced once per spawn and not reset between waves (reset only by `Reset`/`Start`):
  - 0=(16,16)
  - 1=(304,16)
  - 2=(16,224)
  - 3=(304,224)
- All coordinates fit in 9 bits unsigned.

**Kills**
- Kill_Req is honoured in SPAWNING, WAIT_CLEAR and WAVE_REST only.
- A `Kill_Req` bit on an alive slot clears that slot at the edge.
- `Kill_Count` adds the popcount of the effective kills (`Kill_Req & Enemy_Alive`), saturating at 255.
- `Kill_Req` bits on dead slots are ignored and not counted.

**Simultaneous events**
- The free-slot search uses the alive mask before this edge's kills. A slot killed in frame N can be respawned no earlier than frame N+1.
- A kill and the wave-clear check in the same frame: WAIT_CLEAR evaluates the post-kill mask next frame, so WAVE_REST entry is one frame after the last kill.

## Timing

- All outputs are registered and change only on `frame_clk` edges.
- Reset values:
  - state=IDLE, `Enemy_Alive`=0, `Spawn_Valid`=0, `Spawn_Slot`=0;
  - `Spawn_X`=0, `Spawn_Y`=0, `Wave_Num`=0, `Kill_Count`=0, `Game_Over`=0;
  - spawn-point index=0, timer=0.
- `Start` sampled at edge N (from IDLE): state=SPAWNING after edge N; first spawn at edge N+1, visible after it. At that point `Spawn_Valid`=1, `Spawn_Slot`=0, position (16,16), and `Enemy_Alive[0]`=1.
- Subsequent spawns are exactly SPAWN_INTERVAL frames apart when slots are free.
- `Spawn_Valid` is high for exactly one frame per spawn and never on consecutive frames unless SPAWN_INTERVAL=1.
- `Reset` mid-game returns to the reset values at the next edge, overriding every input.
- Timer width is sized to hold max(SPAWN_INTERVAL, WAVE_GAP)-1.

## Test plan

1. **Reset, then start.** Reset 2 frames, then `Start` 1 frame. Expected: all outputs 0 during reset; one frame after the Start edge, `Spawn_Valid`=1, slot 0, (16,16), `Wave_Num`=1; next spawn slot 1 at (304,16) exactly 120 frames later.
2. **Full pool.** With NUM_ENEMY=4 and no kills, 4 spawns fill the mask to 4'b1111 and the timer stalls at 0. Then `Kill_Req`=4'b0100 at frame N. Expected: alive=4'b1011 after N, no spawn at N; spawn into slot 2 at N+1 using point 0 (wrapped); `Kill_Count`=1.
3. **Multi-kill with a dead slot.** `Kill_Req`=4'b1111 while alive=4'b0101. Expected: alive=0, `Kill_Count`+=2.
4. **Wave cycle.** WAVE_SIZE=2, WAVE_GAP=5. Spawn 2, kill both in frame N. Expected: WAVE_REST entered after N+1; next spawn (slot 0) after 5 rest frames plus 1; `Wave_Num`=2.
5. **Player death.** Assert `Player_Dead` in the same frame as a due spawn and a `Kill_Req`. Expected: no `Spawn_Valid`, mask and `Kill_Count` unchanged, `Game_Over`=1. Then `Start`: mask=0, `Kill_Count`=0, `Wave_Num`=1, spawn the following frame.
6. **Saturation and reset mid-game.** Drive 260 kills. Expected: `Kill_Count` holds at 255. Then `Reset` mid-WAVE_REST: all outputs return to reset values after the edge.

Source files
------------

// File: rtl/enemy_spawn_scheduler.sv
// Enemy pool scheduler: spawns enemies into free slots on a fixed cadence,
// retires slots on kill requests, and sequences waves until the player dies.
module enemy_spawn_scheduler #(
    parameter int NUM_ENEMY      = 4,
    parameter int SPAWN_INTERVAL = 120,
    parameter int WAVE_SIZE      = 8,
    parameter int WAVE_GAP       = 240
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Player_Dead,
    input  logic [NUM_ENEMY-1:0] Kill_Req,
    output logic [NUM_ENEMY-1:0] Enemy_Alive,
    output logic                 Spawn_Valid,
    output logic [2:0]           Spawn_Slot,
    output logic [8:0]           Spawn_X,
    output logic [8:0]           Spawn_Y,
    output logic [3:0]           Wave_Num,
    output logic [7:0]           Kill_Count,
    output logic                 Game_Over
);

    localparam int TMAX = ((SPAWN_INTERVAL > WAVE_GAP) ? SPAWN_INTERVAL : WAVE_GAP) - 1;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0]        T_SPAWN   = TW'(SPAWN_INTERVAL - 1);
    localparam logic [TW-1:0]        T_GAP     = TW'(WAVE_GAP - 1);
    localparam logic [7:0]           WAVE_LAST = 8'(WAVE_SIZE);
    localparam logic [NUM_ENEMY-1:0] SLOT_ONE  = NUM_ENEMY'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWNING,
        S_WAIT_CLEAR,
        S_WAVE_REST,
        S_GAME_OVER
    } state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
    } point_t;

    // Corner spawn points, visited in rotating order.
    function automatic point_t spawn_point(input logic [1:0] idx);
        point_t p;
        p.x = idx[0] ? 9'd304 : 9'd16;
        p.y = idx[1] ? 9'd224 : 9'd16;
        return p;
    endfunction

    state_t                 r_state,       w_state_nxt;
    logic [NUM_ENEMY-1:0]   r_alive,       w_alive_nxt;
    logic                   r_spawn_valid, w_spawn_valid_nxt;
    logic [2:0]             r_spawn_slot,  w_spawn_slot_nxt;
    logic [8:0]             r_spawn_x,     w_spawn_x_nxt;
    logic [8:0]             r_spawn_y,     w_spawn_y_nxt;
    logic [3:0]             r_wave_num,    w_wave_num_nxt;
    logic [7:0]             r_kill_count,  w_kill_count_nxt;
    logic                   r_game_over,   w_game_over_nxt;
    logic [1:0]             r_point_idx,   w_point_idx_nxt;
    logic [TW-1:0]          r_timer,       w_timer_nxt;
    logic [7:0]             r_spawn_cnt,   w_spawn_cnt_nxt;

    logic                   w_free_found;
    logic [2:0]             w_free_slot;
    logic [NUM_ENEMY-1:0]   w_spawn_mask;
    logic [NUM_ENEMY-1:0]   w_kill_eff;
    logic [3:0]             w_kill_pop;
    logic [8:0]             w_kill_sum;
    logic [7:0]             w_kill_sat;
    logic [7:0]             w_cnt_inc;
    logic [3:0]             w_wave_inc;
    point_t                 w_point;

    // Lowest-index free slot, searched on the mask before this frame's kills.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_free_found = 1'b0;
        w_free_slot  = 3'd0;
        for (int i = NUM_ENEMY - 1; i >= 0; i--) begin
            if (!r_alive[i]) begin
                w_free_found = 1'b1;
                w_free_slot  = 3'(i);
            end
        end
    end

    always_comb begin
        w_kill_pop = 4'd0;
        for (int i = 0; i < NUM_ENEMY; i++) begin
            w_kill_pop = w_kill_pop + {3'd0, w_kill_eff[i]};
        end
    end

    assign w_spawn_mask = SLOT_ONE << w_free_slot;
    assign w_kill_eff   = Kill_Req & r_alive;
    assign w_kill_sum   = {1'b0, r_kill_count} + {5'd0, w_kill_pop};
    assign w_kill_sat   = w_kill_sum[8] ? 8'hFF : w_kill_sum[7:0];
    assign w_cnt_inc    = r_spawn_cnt + 8'd1;
    assign w_wave_inc   = (r_wave_num == 4'd15) ? 4'd15 : r_wave_num + 4'd1;
    assign w_point      = spawn_point(r_point_idx);

    always_comb begin
        w_state_nxt       = r_state;
        w_alive_nxt       = r_alive;
        w_spawn_valid_nxt = 1'b0;
        w_spawn_slot_nxt  = r_spawn_slot;
        w_spawn_x_nxt     = r_spawn_x;
        w_spawn_y_nxt     = r_spawn_y;
        w_wave_num_nxt    = r_wave_num;
        w_kill_count_nxt  = r_kill_count;
        w_game_over_nxt   = r_game_over;
        w_point_idx_nxt   = r_point_idx;
        w_timer_nxt       = r_timer;
        w_spawn_cnt_nxt   = r_spawn_cnt;

        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (Start) begin
                    w_state_nxt      = S_SPAWNING;
                    w_alive_nxt      = '0;
                    w_kill_count_nxt = 8'd0;
                    w_spawn_cnt_nxt  = 8'd0;
                    w_wave_num_nxt   = 4'd1;
                    w_timer_nxt      = '0;
                    w_point_idx_nxt  = 2'd0;
                    w_game_over_nxt  = 1'b0;
                end
            end

            S_SPAWNING, S_WAIT_CLEAR, S_WAVE_REST: begin
                if (Player_Dead) begin
                    // Everything freezes; only the state and flag move.
                    w_state_nxt     = S_GAME_OVER;
                    w_game_over_nxt = 1'b1;
                end else begin
                    w_alive_nxt      = r_alive & ~w_kill_eff;
                    w_kill_count_nxt = w_kill_sat;
                    case (r_state)
                        S_SPAWNING: begin
                            if (r_timer != '0) begin
                                w_timer_nxt = r_timer - TW'(1);
                            end else if (w_free_found) begin
                                w_alive_nxt       = (r_alive & ~w_kill_eff) | w_spawn_mask;
                                w_spawn_valid_nxt = 1'b1;
                                w_spawn_slot_nxt  = w_free_slot;
                                w_spawn_x_nxt     = w_point.x;
                                w_spawn_y_nxt     = w_point.y;
                                w_point_idx_nxt   = r_point_idx + 2'd1;
                                w_spawn_cnt_nxt   = w_cnt_inc;
                                w_timer_nxt       = T_SPAWN;
                                if (w_cnt_inc == WAVE_LAST) begin
                                    w_state_nxt = S_WAIT_CLEAR;
                                end
                            end
                        end
                        S_WAIT_CLEAR: begin
                            // Registered mask: a final kill is seen one frame later.
                            if (r_alive == '0) begin
                                w_state_nxt = S_WAVE_REST;
                                w_timer_nxt = T_GAP;
                            end
                        end
                        default: begin
                            if (r_timer != '0) begin
                                w_timer_nxt = r_timer - TW'(1);
                            end else begin
                                w_state_nxt     = S_SPAWNING;
                                w_spawn_cnt_nxt = 8'd0;
                                w_wave_num_nxt  = w_wave_inc;
                            end
                        end
                    endcase
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            r_state       <= S_IDLE;
            r_alive       <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_slot  <= 3'd0;
            r_spawn_x     <= 9'd0;
            r_spawn_y     <= 9'd0;
            r_wave_num    <= 4'd0;
            r_kill_count  <= 8'd0;
            r_game_over   <= 1'b0;
            r_point_idx   <= 2'd0;
            r_timer       <= '0;
            r_spawn_cnt   <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_alive       <= w_alive_nxt;
            r_spawn_valid <= w_spawn_valid_nxt;
            r_spawn_slot  <= w_spawn_slot_nxt;
            r_spawn_x     <= w_spawn_x_nxt;
            r_spawn_y     <= w_spawn_y_nxt;
            r_wave_num    <= w_wave_num_nxt;
            r_kill_count  <= w_kill_count_nxt;
            r_game_over   <= w_game_over_nxt;
            r_point_idx   <= w_point_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_spawn_cnt   <= w_spawn_cnt_nxt;
        end
    end

    assign Enemy_Alive = r_alive;
    assign Spawn_Valid = r_spawn_valid;
    assign Spawn_Slot  = r_spawn_slot;
    assign Spawn_X     = r_spawn_x;
    assign Spawn_Y     = r_spawn_y;
    assign Wave_Num    = r_wave_num;
    assign Kill_Count  = r_kill_count;
    assign Game_Over   = r_game_over;

endmodule
